// File: rtl/hash_pkg.sv
// Shared defaults and the FSM state encoding for the hash message feeder.
package hash_pkg;
  localparam int DEPTH_DEF    = 16;
  localparam int BYTE_GAP_DEF = 4;
  localparam int DIG_LAT_DEF  = 3;
  localparam int TIMEOUT_DEF  = 255;
  localparam int TMR_W        = 16;

  typedef enum logic [2:0] {
    IDLE,
    FEED,
    GAP,
    WAIT_DIG,
    OUT
  } state_t;
endpackage

// File: rtl/feeder_byte_buf.sv
// DEPTH x 8 message byte store with write pointer, read pointer and byte count.
module feeder_byte_buf #(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             rd_en,
  input  logic             clr,
  output logic [7:0]       rd_data,
  output logic [CNT_W-1:0] count,
  output logic             remaining
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [7:0]       mem [DEPTH];
  logic [CNT_W-1:0] wr_ptr;
  logic [CNT_W-1:0] rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + CNT_W'(1);
        count  <= count + CNT_W'(1);
      end
      if (rd_en) rd_ptr <= rd_ptr + CNT_W'(1);
    end
  end

  // Storage is not reset; stale bytes are unreachable once the pointers clear.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[PTR_W-1:0]] <= wr_data;
  end

  assign rd_data   = mem[rd_ptr[PTR_W-1:0]];
  assign remaining = (rd_ptr != count);
endmodule

// File: rtl/hash_msg_feeder.sv
// Buffers a host message, replays it to a hash core at a fixed byte spacing,
// then captures the digest (or flags a timeout) and hands it back to the host.
//
// state    | meaning
// IDLE     | accepting host bytes into the buffer
// FEED     | one-cycle M_valid strobe of the next buffered byte
// GAP      | spacing between strobes
// WAIT_DIG | waiting for hash_ready (latency window, then timeout)
// OUT      | digest held for the host until dig_ready
module hash_msg_feeder
  import hash_pkg::*;
#(
  parameter int DEPTH    = DEPTH_DEF,
  parameter int BYTE_GAP = BYTE_GAP_DEF,
  parameter int DIG_LAT  = DIG_LAT_DEF,
  parameter int TIMEOUT  = TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        M_valid,
  output logic [7:0]  message,
  output logic [63:0] counter,
  input  logic        hash_ready,
  input  logic [31:0] digest_out,
  output logic        dig_valid,
  output logic [31:0] dig_data,
  output logic        dig_err,
  output logic        dig_trunc,
  input  logic        dig_ready,
  output logic        busy
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(BYTE_GAP - 2);
  localparam logic [TMR_W-1:0] WAIT_LOAD = TMR_W'(DIG_LAT + TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMO_LIM   = TMR_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(DEPTH - 1);

  state_t           state, next_state;
  logic [TMR_W-1:0] tmr;
  logic             accept, final_byte, capture, timed_out, out_done;
  logic [7:0]       buf_rd, msg_q;
  logic [CNT_W-1:0] buf_count;
  logic             buf_remaining;

  assign accept     = in_valid && in_ready;
  assign final_byte = accept && (in_last || (buf_count == LAST_IDX));
  // The first DIG_LAT cycles of WAIT_DIG have tmr >= TIMEOUT, masking hash_ready.
  assign capture    = (state == WAIT_DIG) && (tmr < TMO_LIM) && hash_ready;
  assign timed_out  = (state == WAIT_DIG) && (tmr == '0) && !capture;
  assign out_done   = dig_valid && dig_ready;

  feeder_byte_buf #(
    .DEPTH(DEPTH),
    .CNT_W(CNT_W)
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (accept),
    .wr_data  (in_data),
    .rd_en    (state == FEED),
    .clr      (out_done),
    .rd_data  (buf_rd),
    .count    (buf_count),
    .remaining(buf_remaining)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (final_byte) next_state = FEED;
      FEED:     next_state = GAP;
      GAP:      if (tmr == '0) next_state = buf_remaining ? FEED : WAIT_DIG;
      WAIT_DIG: if (capture || timed_out) next_state = OUT;
      OUT:      if (dig_ready) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    M_valid   = 1'b0;
    dig_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = rst_n;
        busy     = 1'b0;
      end
      FEED:    M_valid   = 1'b1;
      OUT:     dig_valid = 1'b1;
      default: ;
    endcase
  end

  // Down-counter reloaded on every state change, terminal count at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr <= '0;
    end else if (next_state != state) begin
      case (next_state)
        GAP:      tmr <= GAP_LOAD;
        WAIT_DIG: tmr <= WAIT_LOAD;
        default:  tmr <= '0;
      endcase
    end else if (tmr != '0) begin
      tmr <= tmr - TMR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_q     <= '0;
      counter   <= '0;
      dig_data  <= '0;
      dig_err   <= 1'b0;
      dig_trunc <= 1'b0;
    end else begin
      if (state == FEED) msg_q <= buf_rd;
      if (final_byte) begin
        counter   <= {{(64 - CNT_W){1'b0}}, buf_count + CNT_W'(1)};
        dig_trunc <= !in_last;
      end
      if (capture) begin
        dig_data <= digest_out;
      end else if (timed_out) begin
        dig_data <= '0;
        dig_err  <= 1'b1;
      end
      if (out_done) begin
        counter   <= '0;
        dig_data  <= '0;
        dig_err   <= 1'b0;
        dig_trunc <= 1'b0;
      end
    end
  end

  // The byte is shown live during FEED and held from the register afterwards.
  assign message = (state == FEED) ? buf_rd : msg_q;
endmodule

// File: tb/tb_hash_msg_feeder.sv
// Self-checking bench for hash_msg_feeder: message table plus scoreboard queues.
module tb_hash_msg_feeder;
  localparam int DEPTH    = 16;
  localparam int BYTE_GAP = 4;
  localparam int DIG_LAT  = 3;
  localparam int TIMEOUT  = 255;

  typedef struct {
    int           len;
    logic [127:0] data;
    bit           last;
    logic [31:0]  digest;
    int           hr;
    bit           tmo;
    int           rdy;
    logic [31:0]  exp_data;
    bit           exp_err;
    bit           exp_trunc;
  } vec_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic        trunc;
  } dig_exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic        M_valid;
  logic [7:0]  message;
  logic [63:0] counter;
  logic        hash_ready = 1'b0;
  logic [31:0] digest_out = '0;
  logic        dig_valid;
  logic [31:0] dig_data;
  logic        dig_err;
  logic        dig_trunc;
  logic        dig_ready = 1'b0;
  logic        busy;

  int          total = 0;
  int          bad = 0;
  longint      cyc = 0;
  int          pulse_total = 0;
  int          msg_pulses = 0;
  longint      last_pulse_cyc = 0;
  logic [7:0]  held_msg = '0;
  logic [7:0]  exp_b;
  logic [63:0] exp_len = '0;
  int          base = 0;
  logic [7:0]  exp_msg_q[$];
  dig_exp_t    exp_dig_q[$];
  vec_t        vecs[7];

  hash_msg_feeder #(
    .DEPTH(DEPTH), .BYTE_GAP(BYTE_GAP), .DIG_LAT(DIG_LAT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .M_valid(M_valid), .message(message),
    .counter(counter), .hash_ready(hash_ready), .digest_out(digest_out),
    .dig_valid(dig_valid), .dig_data(dig_data), .dig_err(dig_err),
    .dig_trunc(dig_trunc), .dig_ready(dig_ready), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Monitor: pops expected bytes on each strobe, checks spacing, length and hold.
  always @(negedge clk) begin
    if (rst_n) begin
      if (!busy) msg_pulses = 0;
      if (M_valid) begin
        check("pulse_expected", 64'(exp_msg_q.size() != 0), 64'd1);
        if (exp_msg_q.size() != 0) begin
          exp_b = exp_msg_q.pop_front();
          check("message", 64'(message), 64'(exp_b));
        end
        check("counter_feed", counter, exp_len);
        if (msg_pulses != 0) check("pulse_spacing", 64'(cyc - last_pulse_cyc), 64'(BYTE_GAP));
        last_pulse_cyc = cyc;
        held_msg = message;
        msg_pulses++;
        pulse_total++;
      end else if (busy && msg_pulses != 0) begin
        check("message_hold", 64'(message), 64'(held_msg));
      end
    end
  end

  task automatic push_and_drive(input vec_t v);
    dig_exp_t d;
    for (int i = 0; i < v.len; i++) exp_msg_q.push_back(v.data[i*8 +: 8]);
    d.data  = v.exp_data;
    d.err   = v.exp_err;
    d.trunc = v.exp_trunc;
    exp_dig_q.push_back(d);
    exp_len    = 64'(v.len);
    base       = pulse_total;
    digest_out = v.digest;
    for (int i = 0; i < v.len; i++) begin
      in_valid = 1'b1;
      in_data  = v.data[i*8 +: 8];
      in_last  = v.last && (i == v.len - 1);
      check("in_ready_idle", 64'(in_ready), 64'd1);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int          n;
    longint      lp;
    int          lat;
    logic [31:0] held;
    dig_exp_t    d;
    push_and_drive(v);
    n = 0;
    while (pulse_total - base < v.len && n < 400) begin step(); n++; end
    check("pulse_count", 64'(pulse_total - base), 64'(v.len));
    lp = last_pulse_cyc;
    n = 0;
    while (!dig_valid && n < 600) begin
      if (!v.tmo && cyc >= lp + longint'(v.hr)) hash_ready = 1'b1;
      step();
      n++;
    end
    check("dig_valid_seen", 64'(dig_valid), 64'd1);
    if (v.tmo) lat = BYTE_GAP + DIG_LAT + TIMEOUT;
    else       lat = ((v.hr > BYTE_GAP + DIG_LAT) ? v.hr : BYTE_GAP + DIG_LAT) + 1;
    check("dig_latency", 64'(cyc - lp), 64'(lat));
    hash_ready = 1'b0;
    check("counter_out", counter, 64'(v.len));
    check("busy_out", 64'(busy), 64'd1);
    check("in_ready_out", 64'(in_ready), 64'd0);
    held = dig_data;
    for (int i = 0; i < v.rdy; i++) begin
      step();
      check("dig_hold", 64'(dig_data), 64'(held));
      check("dig_valid_hold", 64'(dig_valid), 64'd1);
      check("in_ready_hold", 64'(in_ready), 64'd0);
    end
    check("dig_expected", 64'(exp_dig_q.size() != 0), 64'd1);
    if (exp_dig_q.size() != 0) begin
      d = exp_dig_q.pop_front();
      check("dig_data", 64'(dig_data), 64'(d.data));
      check("dig_err", 64'(dig_err), 64'(d.err));
      check("dig_trunc", 64'(dig_trunc), 64'(d.trunc));
    end
    dig_ready = 1'b1;
    step();
    dig_ready = 1'b0;
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_in_ready", 64'(in_ready), 64'd1);
    check("idle_dig_valid", 64'(dig_valid), 64'd0);
    check("idle_flags", 64'({dig_err, dig_trunc}), 64'd0);
    check("idle_counter", counter, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{len:1,  data:128'h41, last:1'b1, digest:32'hDEADBEEF, hr:5, tmo:1'b0, rdy:0,
                exp_data:32'hDEADBEEF, exp_err:1'b0, exp_trunc:1'b0};
    vecs[1] = '{len:3,  data:128'h636261, last:1'b1, digest:32'h12345678, hr:2, tmo:1'b0, rdy:0,
                exp_data:32'h12345678, exp_err:1'b0, exp_trunc:1'b0};
    vecs[2] = '{len:16, data:128'h0F0E0D0C0B0A09080706050403020100, last:1'b0,
                digest:32'hCAFEF00D, hr:0, tmo:1'b0, rdy:0,
                exp_data:32'hCAFEF00D, exp_err:1'b0, exp_trunc:1'b1};
    vecs[3] = '{len:2,  data:128'h5A11, last:1'b1, digest:32'h99999999, hr:0, tmo:1'b1, rdy:0,
                exp_data:32'h0, exp_err:1'b1, exp_trunc:1'b0};
    vecs[4] = '{len:5,  data:128'h5544332211, last:1'b1, digest:32'hA5A55A5A, hr:9, tmo:1'b0, rdy:10,
                exp_data:32'hA5A55A5A, exp_err:1'b0, exp_trunc:1'b0};
    vecs[5] = '{len:4,  data:128'hD4C3B2A1, last:1'b1, digest:32'h0BADF00D, hr:1, tmo:1'b0, rdy:0,
                exp_data:32'h0BADF00D, exp_err:1'b0, exp_trunc:1'b0};
    vecs[6] = '{len:1,  data:128'h7E, last:1'b1, digest:32'h600DCAFE, hr:5, tmo:1'b0, rdy:2,
                exp_data:32'h600DCAFE, exp_err:1'b0, exp_trunc:1'b0};

    // Reset values while rst_n is held low.
    step();
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_M_valid", 64'(M_valid), 64'd0);
    check("rst_message", 64'(message), 64'd0);
    check("rst_counter", counter, 64'd0);
    check("rst_dig_valid", 64'(dig_valid), 64'd0);
    check("rst_dig_data", 64'(dig_data), 64'd0);
    check("rst_flags", 64'({dig_err, dig_trunc}), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    for (int k = 0; k < 5; k++) run_vec(vecs[k]);

    // Reset during the second GAP of a 4-byte message aborts it.
    push_and_drive(vecs[5]);
    for (int n = 0; n < 100 && pulse_total - base < 2; n++) step();
    check("abort_pulses_before", 64'(pulse_total - base), 64'd2);
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("abort_M_valid", 64'(M_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd0);
    exp_msg_q.delete();
    exp_dig_q.delete();
    step();
    rst_n = 1'b1;
    step();
    for (int n = 0; n < 30; n++) step();
    check("abort_no_more_pulses", 64'(pulse_total - base), 64'd2);
    check("abort_idle", 64'({busy, in_ready}), 64'b01);

    run_vec(vecs[6]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hash_msg_feeder.md
HASH_MSG_FEEDER -- requirements
Module: hash_msg_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 16, max message bytes buffered.
REQ-002 SHALL have parameter BYTE_GAP, default 4, cycles between successive M_valid pulses (minimum 4).
REQ-003 SHALL have parameter DIG_LAT, default 3, minimum cycles after last M_valid before hash_ready is sampled.
REQ-004 SHALL have parameter TIMEOUT, default 255, max cycles waiting for hash_ready.
REQ-005 clk  input  1  single clock; all flops on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  host byte valid.
REQ-008 in_data  input  8  host message byte.
REQ-009 in_last  input  1  marks final byte of message.
REQ-010 in_ready  output  1  feeder accepts byte.
REQ-011 M_valid  output  1  one-cycle strobe to hash core.
REQ-012 message  output  8  byte presented to hash core.
REQ-013 counter  output  64  message length in bytes, to hash core.
REQ-014 hash_ready  input  1  hash core digest-valid level.
REQ-015 digest_out  input  32  hash core digest.
REQ-016 dig_valid  output  1  captured digest valid to host.
REQ-017 dig_data  output  32  captured digest.
REQ-018 dig_err  output  1  timeout occurred; dig_data is 0.
REQ-019 dig_trunc  output  1  message truncated at DEPTH bytes.
REQ-020 dig_ready  input  1  host accepts digest.
REQ-021 busy  output  1  high in any state except IDLE.

Function
REQ-022 FSM states SHALL be IDLE, FEED, GAP, WAIT_DIG, OUT.
REQ-023 IDLE: in_ready=1; byte accepted when in_valid&&in_ready, written to buffer, length count +1.
REQ-024 Accepting a byte with in_last=1, or the DEPTH-th byte, SHALL move to FEED next cycle; DEPTH-th byte without in_last sets dig_trunc.
REQ-025 in_ready SHALL be 0 in every state but IDLE.
REQ-026 counter SHALL equal the final byte count (1..DEPTH, zero-extended) from FEED entry until OUT exit, and be stable throughout.
REQ-027 FEED: M_valid=1 for exactly one cycle, message=buffer[rd_ptr], rd_ptr +1; then GAP.
REQ-028 message SHALL hold its value from the M_valid cycle until the next M_valid cycle.
REQ-029 GAP: count BYTE_GAP-1 cycles; then FEED if bytes remain, else WAIT_DIG; pulse spacing exactly BYTE_GAP cycles.
REQ-030 WAIT_DIG: ignore hash_ready for the first DIG_LAT cycles; thereafter first cycle with hash_ready=1 captures digest_out into dig_data, goes to OUT.
REQ-031 If TIMEOUT cycles elapse in WAIT_DIG without capture, SHALL go to OUT with dig_err=1, dig_data=0.
REQ-032 OUT: dig_valid=1; dig_data/dig_err/dig_trunc stable until dig_valid&&dig_ready; then IDLE, pointers/count cleared.
REQ-033 dig_err, dig_trunc SHALL clear on OUT exit.
REQ-034 M_valid SHALL be 0 in all states except FEED.

Reset
REQ-035 rst_n low SHALL force IDLE immediately, regardless of state.
REQ-036 Reset values: in_ready=0 while rst_n low then 1, M_valid=0, message=0, counter=0, dig_valid=0, dig_data=0, dig_err=0, dig_trunc=0, busy=0.
REQ-037 Reset mid-FEED/GAP SHALL abort the message; no further M_valid pulses; buffer contents discarded.

Structure
REQ-038 Package hash_pkg SHALL hold DEPTH, BYTE_GAP, DIG_LAT, TIMEOUT defaults and the FSM state enum.
REQ-039 Buffer SHALL be sub-module feeder_byte_buf: DEPTH x 8 register file with write pointer, read pointer, count.

Verification
REQ-040 1 byte 0x41 with in_last -> one M_valid pulse message=0x41, counter=1; hash_ready high 5 cycles later -> dig_valid, dig_data=digest_out.
REQ-041 "abc" (0x61,0x62,0x63, last on 0x63) -> 3 pulses 4 cycles apart, counter=3 throughout, in_ready=0 until digest accepted.
REQ-042 16 bytes 0x00..0x0F, no in_last -> 16 pulses, counter=16, dig_trunc=1.
REQ-043 hash_ready held 0 -> after DIG_LAT+255 cycles in WAIT_DIG, dig_valid=1, dig_err=1, dig_data=0.
REQ-044 dig_ready held 0 for 10 cycles in OUT -> dig_data stable, in_ready=0; acceptance -> IDLE next cycle.
REQ-045 rst_n low during second GAP of 4-byte message -> M_valid 0, busy 0, no further pulses; new 1-byte message then hashes normally.
